dram_cmd_intake: RTL and testbench

Controller-side responder for the host command interface. It accepts 34-bit access commands with write data, and grants per-bank permission on ba_cmd_pm. Accepted commands are buffered in an in-order FIFO and presented to the bank scheduler. The read-data return path (read_data / read_data_valid) is registered back to the host.

---
 rtl/dram_cmd_pkg.sv | 35 +++
 rtl/dram_cmd_intake_if.sv | 24 ++
 rtl/dram_cmd_fifo.sv | 52 +++++
 rtl/dram_cmd_intake.sv | 128 ++++++++++++
 tb/tb_dram_cmd_intake.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_cmd_pkg.sv
// dram_cmd_pkg: shared constants for the DRAM host-command intake block.
//   - Command field bit positions (RANK_MSB .. BANK_LSB) for the 34-bit command.
//   - CMD_W, RW_WRITE / RW_READ encodings, bank count.
//   - cmd_illegal(): reserved-bit / rank legality test, used only when
//     DRAM_CMD_CHECK_EN is defined.
package dram_cmd_pkg;

    localparam int CMD_W     = 34;
    localparam int NUM_BANKS = 8;

    localparam int RANK_MSB  = 33;
    localparam int RANK_LSB  = 32;
    localparam int RW_BIT    = 31;
    localparam int RSV0_BIT  = 30;
    localparam int ROW_MSB   = 29;
    localparam int ROW_LSB   = 17;
    localparam int RSV1_BIT  = 16;
    localparam int BL_BIT    = 15;
    localparam int RSV2_BIT  = 14;
    localparam int AP_BIT    = 13;
    localparam int COL_MSB   = 12;
    localparam int COL_LSB   = 3;
    localparam int BANK_MSB  = 2;
    localparam int BANK_LSB  = 0;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Only rank 0 is populated; any reserved bit set marks a malformed command.
    function automatic logic cmd_illegal(input logic [CMD_W-1:0] c);
        return c[RSV0_BIT] | c[RSV1_BIT] | c[RSV2_BIT] |
               (c[RANK_MSB:RANK_LSB] != 2'd0);
    endfunction

endpackage

// File: rtl/dram_cmd_intake_if.sv
// dram_cmd_intake_if: host-side command / read-return bundle.
//   master (host)  : drives command, valid, write_data; sees ba_cmd_pm,
//                    read_data, read_data_valid.
//   slave (intake) : the reverse.
interface dram_cmd_intake_if #(
    parameter int DQ_BITS = 16
);
    logic [dram_cmd_pkg::CMD_W-1:0]     command;
    logic                               valid;
    logic [DQ_BITS*8-1:0]               write_data;
    logic [dram_cmd_pkg::NUM_BANKS-1:0] ba_cmd_pm;
    logic [DQ_BITS*8-1:0]               read_data;
    logic                               read_data_valid;

    modport master (
        output command, valid, write_data,
        input  ba_cmd_pm, read_data, read_data_valid
    );

    modport slave (
        input  command, valid, write_data,
        output ba_cmd_pm, read_data, read_data_valid
    );
endinterface

// File: rtl/dram_cmd_fifo.sv
// dram_cmd_fifo: generic synchronous first-word-fall-through FIFO.
//   clk, rst_n      : clock, async active-low reset (pointers only)
//   push, push_data : write side; ignored when full
//   pop             : advance head; ignored when empty
//   head            : current head entry, read combinationally from storage
//   count/full/empty: occupancy
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dram_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             wr_en, rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + PTR_ONE;
            if (rd_en) rptr <= rptr + PTR_ONE;
        end
    end

    // Storage is not reset: nothing beyond the pointers is observable as valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rptr[AW-1:0]];
    assign count = wptr - rptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (wptr == rptr);

endmodule

// File: rtl/dram_cmd_intake.sv
// dram_cmd_intake: controller-side responder for the host command interface.
//   clk, power_on_rst_n : clock, async active-low reset
//   host (slave)        : command/valid/write_data in; ba_cmd_pm permit,
//                         read_data/read_data_valid return out
//   sch_valid/ready/cmd/wdata : FWFT command stream to the bank scheduler
//   dram_rdata(_valid)  : PHY read data, returned to host one cycle later
//   err_drop            : sticky, command arrived without permit
//   err_illegal         : sticky, malformed command (DRAM_CMD_CHECK_EN only)
// Optional build macro: DRAM_CMD_CHECK_EN rejects commands with reserved
// bits set or nonzero rank instead of queueing them.
module dram_cmd_intake
    import dram_cmd_pkg::*;
#(
    parameter int DQ_BITS      = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int BANK_MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 power_on_rst_n,
    dram_cmd_intake_if.slave     host,
    output logic                 sch_valid,
    input  logic                 sch_ready,
    output logic [CMD_W-1:0]     sch_cmd,
    output logic [DQ_BITS*8-1:0] sch_wdata,
    input  logic [DQ_BITS*8-1:0] dram_rdata,
    input  logic                 dram_rdata_valid,
`ifdef DRAM_CMD_CHECK_EN
    output logic                 err_illegal,
`endif
    output logic                 err_drop
);
    localparam int DW    = DQ_BITS * 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(BANK_MAX_OUT + 1);

    logic [2:0]                      in_bank, pop_bank;
    logic [NUM_BANKS-1:0]            pm;
    logic                            accept, push, pop, illegal;
    logic [CMD_W+DW-1:0]             push_data, head;
    logic [CMD_W-1:0]                head_cmd;
    logic [DW-1:0]                   head_wd;
    logic [AW:0]                     count, count_next;
    logic                            empty, fifo_room, fifo_full_unused;
    logic [NUM_BANKS-1:0][CNT_W-1:0] bank_cnt, bank_cnt_next;

    assign in_bank = host.command[BANK_MSB:BANK_LSB];
    assign accept  = host.valid && pm[in_bank];

`ifdef DRAM_CMD_CHECK_EN
    assign illegal = cmd_illegal(host.command);
`else
    assign illegal = 1'b0;
`endif
    assign push = accept && !illegal;

    // Reads carry no payload; zero it so the scheduler never sees stale data.
    assign push_data = {host.command,
                        (host.command[RW_BIT] == RW_READ) ? {DW{1'b0}} : host.write_data};

    dram_cmd_fifo #(.WIDTH(CMD_W + DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (power_on_rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full_unused),
        .empty     (empty)
    );

    assign head_cmd  = head[CMD_W+DW-1:DW];
    assign head_wd   = head[DW-1:0];
    assign sch_valid = !empty;
    // Gate with valid so an empty FIFO (incl. right after reset) shows zeros.
    assign sch_cmd   = sch_valid ? head_cmd : '0;
    assign sch_wdata = sch_valid ? head_wd  : '0;
    assign pop       = sch_valid && sch_ready;
    assign pop_bank  = head_cmd[BANK_MSB:BANK_LSB];

    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    // One spare entry: a host sampling pm late may land one extra command.
    assign fifo_room  = (count_next <= (AW+1)'(FIFO_DEPTH - 2));

    // Per-bank outstanding counter and registered permit, from next-state values.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic inc, dec;
        assign inc = push && (in_bank == 3'(b));
        assign dec = pop && (pop_bank == 3'(b));
        assign bank_cnt_next[b] = bank_cnt[b] + CNT_W'(inc) - CNT_W'(dec);

        always_ff @(posedge clk or negedge power_on_rst_n) begin
            if (!power_on_rst_n) begin
                bank_cnt[b] <= '0;
                pm[b]       <= 1'b1;
            end else begin
                bank_cnt[b] <= bank_cnt_next[b];
                pm[b]       <= fifo_room && (bank_cnt_next[b] < CNT_W'(BANK_MAX_OUT));
            end
        end
    end

    assign host.ba_cmd_pm = pm;

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) err_drop <= 1'b0;
        else if (host.valid && !pm[in_bank]) err_drop <= 1'b1;
    end

`ifdef DRAM_CMD_CHECK_EN
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) err_illegal <= 1'b0;
        else if (accept && illegal) err_illegal <= 1'b1;
    end
`endif

    // Read return: one-cycle delay; data holds between beats.
    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            host.read_data_valid <= 1'b0;
            host.read_data       <= '0;
        end else begin
            host.read_data_valid <= dram_rdata_valid;
            if (dram_rdata_valid) host.read_data <= dram_rdata;
        end
    end

endmodule

// File: tb/tb_dram_cmd_intake.sv
// tb_dram_cmd_intake: directed table + hand sequences + randomized traffic,
// all checked against a queue-based reference model of the intake block.
module tb_dram_cmd_intake;
    logic         clk = 1'b0;
    logic         power_on_rst_n = 1'b0;
    logic         sch_valid, sch_ready;
    logic [33:0]  sch_cmd;
    logic [127:0] sch_wdata, dram_rdata;
    logic         dram_rdata_valid, err_drop;
`ifdef DRAM_CMD_CHECK_EN
    logic         err_illegal;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dram_cmd_intake_if #(.DQ_BITS(16)) hif ();

    dram_cmd_intake #(.DQ_BITS(16), .FIFO_DEPTH(8), .BANK_MAX_OUT(4)) dut (
        .clk              (clk),
        .power_on_rst_n   (power_on_rst_n),
        .host             (hif.slave),
        .sch_valid        (sch_valid),
        .sch_ready        (sch_ready),
        .sch_cmd          (sch_cmd),
        .sch_wdata        (sch_wdata),
        .dram_rdata       (dram_rdata),
        .dram_rdata_valid (dram_rdata_valid),
`ifdef DRAM_CMD_CHECK_EN
        .err_illegal      (err_illegal),
`endif
        .err_drop         (err_drop)
    );

    // ---------------- reference model ----------------
    typedef struct { logic [33:0] cmd; logic [127:0] wd; } ent_t;
    ent_t         q[$];
    logic [7:0]   m_pm;
    bit           m_err, m_ill, m_rdv;
    logic [127:0] m_rd;

    function automatic logic [33:0] mkcmd(input logic [1:0] rank, input logic rw,
                                          input logic [12:0] row, input logic [9:0] col,
                                          input logic [2:0] bank);
        return {rank, rw, 1'b0, row, 1'b0, 1'b0, 1'b0, 1'b0, col, bank};
    endfunction

    function automatic bit bad_cmd(input logic [33:0] c);
`ifdef DRAM_CMD_CHECK_EN
        return (c[33:32] != 0) || c[30] || c[16] || c[14];
`else
        return (c[33:32] == 2'b11) && 1'b0 == c[0] && c[0] == 1'b1; // never true
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_pm = 8'hFF; m_err = 0; m_ill = 0; m_rdv = 0; m_rd = '0;
    endtask

    task automatic model_step(input bit v, input logic [33:0] c, input logic [127:0] wd,
                              input bit rdy, input bit rv, input logic [127:0] rd);
        bit pop, acc;
        pop = (q.size() != 0) && rdy;
        acc = v && m_pm[c[2:0]];
        if (v && !m_pm[c[2:0]]) m_err = 1;
        if (pop) void'(q.pop_front());
        if (acc && bad_cmd(c)) m_ill = 1;
        else if (acc) q.push_back('{c, c[31] ? 128'h0 : wd});
        for (int b = 0; b < 8; b++) begin
            int n = 0;
            foreach (q[i]) if (q[i].cmd[2:0] == 3'(b)) n++;
            m_pm[b] = (q.size() <= 6) && (n < 4);
        end
        m_rdv = rv;
        if (rv) m_rd = rd;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("pm", 128'(hif.ba_cmd_pm), 128'(m_pm));
        chk("sch_valid", 128'(sch_valid), 128'(q.size() != 0));
        chk("sch_cmd", 128'(sch_cmd), q.size() ? 128'(q[0].cmd) : 128'h0);
        chk("sch_wdata", sch_wdata, q.size() ? q[0].wd : 128'h0);
        chk("err_drop", 128'(err_drop), 128'(m_err));
        chk("read_data_valid", 128'(hif.read_data_valid), 128'(m_rdv));
        chk("read_data", hif.read_data, m_rd);
`ifdef DRAM_CMD_CHECK_EN
        chk("err_illegal", 128'(err_illegal), 128'(m_ill));
`endif
    endtask

    // Inputs change at posedge+1; outputs compared at the following posedge+1.
    task automatic cycle(input bit v, input logic [33:0] c, input logic [127:0] wd,
                         input bit rdy, input bit rv, input logic [127:0] rd);
        hif.valid = v; hif.command = c; hif.write_data = wd;
        sch_ready = rdy; dram_rdata_valid = rv; dram_rdata = rd;
        @(posedge clk);
        model_step(v, c, wd, rdy, rv, rd);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        hif.valid = 0; hif.command = '0; hif.write_data = '0;
        sch_ready = 0; dram_rdata_valid = 0; dram_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        power_on_rst_n = 0;
        @(posedge clk); #1;
        power_on_rst_n = 1;
        model_reset();
        chk("rst_pm", 128'(hif.ba_cmd_pm), 128'hFF);
        chk("rst_sch_valid", 128'(sch_valid), 128'h0);
        chk("rst_sch_cmd", 128'(sch_cmd), 128'h0);
        chk("rst_rdv", 128'(hif.read_data_valid), 128'h0);
        chk("rst_err_drop", 128'(err_drop), 128'h0);
    endtask

    typedef struct {
        bit v; logic [33:0] cmd; logic [127:0] wd; bit rdy;
        logic [7:0] e_pm; bit e_sv; bit e_err;
    } vec_t;
    vec_t tbl[9];

    initial begin
        logic [127:0] a5;
        logic [33:0]  c;
        a5 = {16{8'hA5}};
        // write row 3 col 5 bank 0, then hold, pop, then fill bank 2 and overrun it
        tbl[0] = '{1, mkcmd(0, 0, 3, 5, 0), a5, 0, 8'hFF, 1, 0};
        tbl[1] = '{0, '0, '0, 0, 8'hFF, 1, 0};
        tbl[2] = '{0, '0, '0, 1, 8'hFF, 0, 0};
        tbl[3] = '{1, mkcmd(0, 1, 7, 1, 2), a5, 0, 8'hFF, 1, 0};
        tbl[4] = '{1, mkcmd(0, 1, 7, 2, 2), a5, 0, 8'hFF, 1, 0};
        tbl[5] = '{1, mkcmd(0, 1, 7, 3, 2), a5, 0, 8'hFF, 1, 0};
        tbl[6] = '{1, mkcmd(0, 1, 7, 4, 2), a5, 0, 8'hFB, 1, 0};
        tbl[7] = '{1, mkcmd(0, 1, 7, 5, 2), a5, 0, 8'hFB, 1, 1};
        tbl[8] = '{0, '0, '0, 0, 8'hFB, 1, 1};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].v, tbl[i].cmd, tbl[i].wd, tbl[i].rdy, 0, '0);
            chk($sformatf("tbl%0d_pm", i), 128'(hif.ba_cmd_pm), 128'(tbl[i].e_pm));
            chk($sformatf("tbl%0d_sv", i), 128'(sch_valid), 128'(tbl[i].e_sv));
            chk($sformatf("tbl%0d_err", i), 128'(err_drop), 128'(tbl[i].e_err));
            if (i == 0) begin
                chk("head_cmd", 128'(sch_cmd), 128'(mkcmd(0, 0, 3, 5, 0)));
                chk("head_wdata", sch_wdata, a5);
            end
        end

        // FIFO occupancy limit: 7 entries across banks 0..3 closes every permit
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(1, mkcmd(0, 0, 13'(i), 10'(i), 3'(i % 4)), 128'($urandom), 0, 0, '0);
            chk("fill_pm", 128'(hif.ba_cmd_pm), (i == 6) ? 128'h00 : 128'hFF);
        end
        cycle(0, '0, '0, 1, 0, '0);
        chk("fill_pop_pm", 128'(hif.ba_cmd_pm), 128'hFF);

        // same-bank push+pop leaves bank 1 at 2 outstanding
        do_reset();
        cycle(1, mkcmd(0, 1, 1, 1, 1), '0, 0, 0, '0);
        cycle(1, mkcmd(0, 1, 1, 2, 1), '0, 0, 0, '0);
        cycle(1, mkcmd(0, 1, 1, 3, 1), '0, 1, 0, '0);
        chk("pp_pm1_a", 128'(hif.ba_cmd_pm[1]), 128'h1);
        cycle(1, mkcmd(0, 1, 1, 4, 1), '0, 0, 0, '0);
        chk("pp_pm1_b", 128'(hif.ba_cmd_pm[1]), 128'h1);
        cycle(1, mkcmd(0, 1, 1, 5, 1), '0, 0, 0, '0);
        chk("pp_pm1_c", 128'(hif.ba_cmd_pm[1]), 128'h0);
        chk("pp_err", 128'(err_drop), 128'h0);

        // read return: three beats, then hold
        for (int i = 1; i <= 3; i++) begin
            cycle(0, '0, '0, 0, 1, 128'(i));
            chk("rd_valid", 128'(hif.read_data_valid), 128'h1);
            chk("rd_data", hif.read_data, 128'(i));
        end
        cycle(0, '0, '0, 0, 0, 128'hDEAD);
        chk("rd_valid_end", 128'(hif.read_data_valid), 128'h0);
        chk("rd_hold", hif.read_data, 128'h3);

        // reset in mid-operation discards queued entries immediately
        do_reset();
        cycle(1, mkcmd(0, 0, 9, 9, 5), 128'h1234, 0, 0, '0);
        cycle(1, mkcmd(0, 0, 9, 8, 5), 128'h5678, 0, 0, '0);
        idle_inputs();
        power_on_rst_n = 0;
        #2;
        chk("async_sv", 128'(sch_valid), 128'h0);
        chk("async_pm", 128'(hif.ba_cmd_pm), 128'hFF);
        chk("async_cmd", 128'(sch_cmd), 128'h0);
        @(posedge clk); #1;
        power_on_rst_n = 1;
        model_reset();
        cycle(0, '0, '0, 1, 0, '0);
        chk("post_rst_sv", 128'(sch_valid), 128'h0);

`ifdef DRAM_CMD_CHECK_EN
        c = mkcmd(0, 0, 2, 2, 0);
        c[30] = 1'b1;
        cycle(1, c, 128'hFFFF, 0, 0, '0);
        chk("ill_flag", 128'(err_illegal), 128'h1);
        chk("ill_sv", 128'(sch_valid), 128'h0);
`else
        c = '0;
`endif

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [33:0] rc;
            rc = {2'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 0) rc[2:0] = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                rc[33:32] = 2'b00; rc[30] = 0; rc[16] = 0; rc[14] = 0;
            end
            cycle($urandom_range(0, 9) < 6, rc, {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
                  {$urandom, $urandom, $urandom, $urandom});
            if (n == 200) begin
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
